iob_aclint: RTL and testbench

Parametrised core-local interruptor for multi-hart IOb-SoC systems. It provides a 64-bit machine timer with per-hart compare registers. It also provides per-hart machine and supervisor software-interrupt bits and a selectable tick source: an external RTC pulse, synchronised internally, or an internal prescaler. It sits on the IOb native bus as a slave beside the CPU cluster and drives the `mtip`/`msip`/`ssip` lines of every hart.

---
 rtl/iob_aclint_if.sv | 26 ++
 rtl/iob_aclint.sv | 209 ++++++++++++++++++++
 tb/tb_iob_aclint.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_aclint_if.sv
// IOb native bus bundle for iob_aclint.
// The master drives avalid/addr/wdata/wstrb. The slave returns ready, and
// rvalid/rdata one cycle after each accepted read.
// A nonzero wstrb marks a write; zero marks a read.
interface iob_aclint_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic                iob_avalid;
  logic [ADDR_W-1:0]   iob_addr;
  logic [DATA_W-1:0]   iob_wdata;
  logic [DATA_W/8-1:0] iob_wstrb;
  logic                iob_rvalid;
  logic [DATA_W-1:0]   iob_rdata;
  logic                iob_ready;

  modport master (
    output iob_avalid, iob_addr, iob_wdata, iob_wstrb,
    input  iob_rvalid, iob_rdata, iob_ready
  );

  modport slave (
    input  iob_avalid, iob_addr, iob_wdata, iob_wstrb,
    output iob_rvalid, iob_rdata, iob_ready
  );
endinterface

// File: rtl/iob_aclint.sv
// iob_aclint: core-local interruptor for N_CORES harts.
// The block contains:
//   - a 64-bit mtime counter that advances on a tick from either the
//     synchronised rtc_i or an internal prescaler;
//   - a per-hart MTIMECMP register and a registered mtip output;
//   - per-hart MSIP and SSIP software-interrupt bits.
// Ports:
//   clk_i, arst_i (async, active-high), cke_i (global hold),
//   rtc_i (async external tick),
//   iob (IOb slave: avalid/addr/wdata/wstrb in; ready/rvalid/rdata out),
//   mtip/msip/ssip (one bit per hart).
module iob_aclint #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int N_CORES = 1
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               cke_i,
  input  logic               rtc_i,
  iob_aclint_if.slave        iob,
  output logic [N_CORES-1:0] mtip,
  output logic [N_CORES-1:0] msip,
  output logic [N_CORES-1:0] ssip
);

  localparam logic [15:0] ADDR_CTRL  = 16'hBFF0;
  localparam logic [15:0] ADDR_PRESC = 16'hBFF4;
  localparam logic [15:0] ADDR_MLO   = 16'hBFF8;
  localparam logic [15:0] ADDR_MHI   = 16'hBFFC;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  logic [63:0]        mtime_q, mtime_d;
  logic [31:0]        shadow_q, shadow_d;
  logic [63:0]        cmp_q [N_CORES];
  logic [63:0]        cmp_d [N_CORES];
  logic [N_CORES-1:0] msip_q, msip_d, ssip_q, ssip_d, mtip_q, mtip_d;
  logic               en_q, en_d, src_q, src_d;
  logic [15:0]        presc_q, presc_d, pcnt_q, pcnt_d;
  logic               s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;

  logic        upper_zero;
  logic [15:0] a;
  logic [11:0] sw_idx;
  logic [10:0] cmp_idx;
  logic        sel_msip, sel_ssip, sel_cmp, sel_ctrl, sel_presc, sel_mlo, sel_mhi;
  logic        rd_en, wr_en;
  logic [31:0] rd_word, wr_word;
  logic        tick_rtc, tick_pre, inc;
  logic        unused_addr_lsb;

  // Any address bits above the 64 KiB map must be zero for a hit.
  if (ADDR_W > 16) begin : g_upper
    assign upper_zero = ~|iob.iob_addr[ADDR_W-1:16];
  end else begin : g_no_upper
    assign upper_zero = 1'b1;
  end

  // Byte-lane bits carry no meaning for word registers.
  assign unused_addr_lsb = ^iob.iob_addr[1:0];

  assign a       = {iob.iob_addr[15:2], 2'b00};
  assign sw_idx  = a[13:2];
  assign cmp_idx = a[13:3];

  assign sel_msip  = upper_zero && (a[15:14] == 2'b00);
  assign sel_cmp   = upper_zero && (a[15:14] == 2'b01);
  assign sel_ssip  = upper_zero && (a[15:14] == 2'b11);
  assign sel_ctrl  = upper_zero && (a == ADDR_CTRL);
  assign sel_presc = upper_zero && (a == ADDR_PRESC);
  assign sel_mlo   = upper_zero && (a == ADDR_MLO);
  assign sel_mhi   = upper_zero && (a == ADDR_MHI);

  assign rd_en = iob.iob_avalid & cke_i & ~|iob.iob_wstrb;
  assign wr_en = iob.iob_avalid & cke_i &  |iob.iob_wstrb;

  // Tick sources: rising edge of synchronised rtc, or prescaler terminal count.
  assign tick_rtc = s2_q & ~s3_q;
  assign tick_pre = (pcnt_q == presc_q);
  assign inc      = en_q & (src_q ? tick_pre : tick_rtc);

  // Current register contents at the addressed location.
  // Unmapped locations and harts that do not exist read as 0.
  always_comb begin
    rd_word = '0;
    if (sel_ctrl)       rd_word = {30'b0, src_q, en_q};
    else if (sel_presc) rd_word = {16'b0, presc_q};
    else if (sel_mlo)   rd_word = mtime_q[31:0];
    else if (sel_mhi)   rd_word = shadow_q;
    for (int h = 0; h < N_CORES; h++) begin
      if (sel_msip && sw_idx == 12'(h)) rd_word = {31'b0, msip_q[h]};
      if (sel_ssip && sw_idx == 12'(h)) rd_word = {31'b0, ssip_q[h]};
      if (sel_cmp && cmp_idx == 11'(h)) rd_word = a[2] ? cmp_q[h][63:32] : cmp_q[h][31:0];
    end
  end

  // Merging the write data into the current contents makes byte strobes
  // uniform across every register width.
  assign wr_word = merge_bytes(rd_word, iob.iob_wdata, iob.iob_wstrb);

  always_comb begin
    mtime_d  = mtime_q;
    shadow_d = shadow_q;
    en_d     = en_q;
    src_d    = src_q;
    presc_d  = presc_q;
    pcnt_d   = pcnt_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    s3_d     = s3_q;
    msip_d   = msip_q;
    ssip_d   = ssip_q;
    mtip_d   = mtip_q;
    for (int h = 0; h < N_CORES; h++) cmp_d[h] = cmp_q[h];
    rvalid_d = rd_en;
    rdata_d  = rd_en ? rd_word : rdata_q;

    if (cke_i) begin
      s1_d   = rtc_i;
      s2_d   = s1_q;
      s3_d   = s2_q;
      pcnt_d = tick_pre ? 16'd0 : pcnt_q + 16'd1;
      if (inc) mtime_d = mtime_q + 64'd1;
      for (int h = 0; h < N_CORES; h++) mtip_d[h] = (mtime_q >= cmp_q[h]);

      // Reading the low word freezes the high word for a tear-free 64-bit read.
      if (rd_en && sel_mlo) shadow_d = mtime_q[63:32];

      if (wr_en) begin
        if (sel_ctrl) begin
          en_d  = wr_word[0];
          src_d = wr_word[1];
          if (wr_word[1] != src_q) pcnt_d = 16'd0;
        end
        if (sel_presc) begin
          presc_d = wr_word[15:0];
          pcnt_d  = 16'd0;
        end
        // A bus write to mtime replaces any tick in the same cycle.
        if (sel_mlo) mtime_d = {mtime_q[63:32], wr_word};
        if (sel_mhi) mtime_d = {wr_word, mtime_q[31:0]};
        for (int h = 0; h < N_CORES; h++) begin
          if (sel_msip && sw_idx == 12'(h)) msip_d[h] = wr_word[0];
          if (sel_ssip && sw_idx == 12'(h)) ssip_d[h] = wr_word[0];
          if (sel_cmp && cmp_idx == 11'(h)) begin
            if (a[2]) cmp_d[h][63:32] = wr_word;
            else      cmp_d[h][31:0]  = wr_word;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      mtime_q  <= '0;
      shadow_q <= '0;
      for (int h = 0; h < N_CORES; h++) cmp_q[h] <= '1;
      msip_q   <= '0;
      ssip_q   <= '0;
      mtip_q   <= '0;
      en_q     <= 1'b1;
      src_q    <= 1'b0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      mtime_q  <= mtime_d;
      shadow_q <= shadow_d;
      cmp_q    <= cmp_d;
      msip_q   <= msip_d;
      ssip_q   <= ssip_d;
      mtip_q   <= mtip_d;
      en_q     <= en_d;
      src_q    <= src_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign iob.iob_ready  = cke_i;
  assign iob.iob_rvalid = rvalid_q;
  assign iob.iob_rdata  = rdata_q;
  assign mtip = mtip_q;
  assign msip = msip_q;
  assign ssip = ssip_q;

endmodule

// File: tb/tb_iob_aclint.sv
// Testbench for iob_aclint with four harts.
// A register-level reference model steps once per accepted clock edge.
// A compare process checks every DUT output against that model on every cycle.
// Directed sequences add literal expectations for the key timing points.
// A randomized phase then mixes bus traffic, rtc edges and clock-enable gaps.
module tb_iob_aclint;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          arst;
  logic          cke;
  logic          rtc;
  logic [NC-1:0] mtip, msip, ssip;
  int            total = 0;
  int            bad   = 0;
  bit            chk_on = 1'b0;

  iob_aclint_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  iob_aclint #(.ADDR_W(16), .DATA_W(32), .N_CORES(NC)) dut (
    .clk_i (clk),
    .arst_i(arst),
    .cke_i (cke),
    .rtc_i (rtc),
    .iob   (bus),
    .mtip  (mtip),
    .msip  (msip),
    .ssip  (ssip)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [63:0]   m_mtime;
  logic [63:0]   m_cmp [NC];
  logic [31:0]   m_shadow;
  logic [NC-1:0] m_msip, m_ssip, e_mtip;
  logic          m_en, m_src;
  logic [15:0]   m_p;
  int            pk;            // accepted edges since the prescaler phase was reset
  logic [2:0]    rtc_hist;      // [0] = rtc seen at the last edge, [1] two edges ago, ...
  logic          e_rvalid;
  logic [31:0]   e_rdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] w);
    int idx;
    if (w == 16'hBFF0) return {30'd0, m_src, m_en};
    if (w == 16'hBFF4) return {16'd0, m_p};
    if (w == 16'hBFF8) return m_mtime[31:0];
    if (w == 16'hBFFC) return m_shadow;
    if (w < 16'h4000) begin
      idx = int'(w) / 4;
      if (idx < NC) return {31'd0, m_msip[idx]};
      return 32'd0;
    end
    if (w < 16'h8000) begin
      idx = (int'(w) - 'h4000) / 8;
      if (idx < NC) return ((int'(w) % 8) == 4) ? m_cmp[idx][63:32] : m_cmp[idx][31:0];
      return 32'd0;
    end
    if (w >= 16'hC000) begin
      idx = (int'(w) - 'hC000) / 4;
      if (idx < NC) return {31'd0, m_ssip[idx]};
    end
    return 32'd0;
  endfunction

  task automatic m_reset();
    m_mtime  = 64'd0;
    for (int h = 0; h < NC; h++) m_cmp[h] = '1;
    m_shadow = 32'd0;
    m_msip   = '0;
    m_ssip   = '0;
    e_mtip   = '0;
    m_en     = 1'b1;
    m_src    = 1'b0;
    m_p      = 16'd0;
    pk       = 0;
    rtc_hist = 3'b000;
    e_rvalid = 1'b0;
    e_rdata  = 32'd0;
  endtask

  task automatic m_step();
    logic        tick, is_rd, is_wr;
    logic [15:0] w;
    logic [31:0] nw;
    logic [63:0] nxt;
    int          idx;
    w     = {bus.iob_addr[15:2], 2'b00};
    is_rd = bus.iob_avalid && (bus.iob_wstrb == 4'd0);
    is_wr = bus.iob_avalid && (bus.iob_wstrb != 4'd0);
    // rtc source: a rise seen two edges back (after the two-stage synchroniser) counts once.
    // prescaler: every (P+1)th edge of the current phase.
    if (m_src) tick = (pk % (int'(m_p) + 1)) == int'(m_p);
    else       tick = rtc_hist[1] && !rtc_hist[2];
    for (int h = 0; h < NC; h++) e_mtip[h] = (m_mtime >= m_cmp[h]);
    e_rvalid = is_rd;
    nw = merge(m_read(w), bus.iob_wdata, bus.iob_wstrb);
    if (is_rd) begin
      e_rdata = m_read(w);
      if (w == 16'hBFF8) m_shadow = m_mtime[63:32];
    end
    nxt = m_mtime + ((tick && m_en) ? 64'd1 : 64'd0);
    pk++;
    if (is_wr) begin
      if (w == 16'hBFF0) begin
        if (nw[1] != m_src) pk = 0;
        m_en  = nw[0];
        m_src = nw[1];
      end else if (w == 16'hBFF4) begin
        m_p = nw[15:0];
        pk  = 0;
      end else if (w == 16'hBFF8) begin
        nxt = {m_mtime[63:32], nw};
      end else if (w == 16'hBFFC) begin
        nxt = {nw, m_mtime[31:0]};
      end else if (w < 16'h4000) begin
        idx = int'(w) / 4;
        if (idx < NC) m_msip[idx] = nw[0];
      end else if (w < 16'h8000) begin
        idx = (int'(w) - 'h4000) / 8;
        if (idx < NC) begin
          if ((int'(w) % 8) == 4) m_cmp[idx][63:32] = nw;
          else                    m_cmp[idx][31:0]  = nw;
        end
      end else if (w >= 16'hC000) begin
        idx = (int'(w) - 'hC000) / 4;
        if (idx < NC) m_ssip[idx] = nw[0];
      end
    end
    m_mtime  = nxt;
    rtc_hist = {rtc_hist[1:0], rtc};
  endtask

  always @(posedge clk or posedge arst) begin
    if (arst)      m_reset();
    else if (!cke) e_rvalid = 1'b0;
    else           m_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      chk("mtip",   mtip,           e_mtip);
      chk("msip",   msip,           m_msip);
      chk("ssip",   ssip,           m_ssip);
      chk("ready",  bus.iob_ready,  cke);
      chk("rvalid", bus.iob_rvalid, e_rvalid);
      chk("rdata",  bus.iob_rdata,  e_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_wr(input logic [15:0] ad, input logic [31:0] d, input logic [3:0] s);
    bus.iob_avalid = 1'b1;
    bus.iob_addr   = ad;
    bus.iob_wdata  = d;
    bus.iob_wstrb  = s;
    @(negedge clk);
    bus.iob_avalid = 1'b0;
    bus.iob_wstrb  = 4'd0;
  endtask

  task automatic do_rd(input string nm, input logic [15:0] ad, input logic [31:0] exp);
    bus.iob_avalid = 1'b1;
    bus.iob_addr   = ad;
    bus.iob_wstrb  = 4'd0;
    @(negedge clk);
    bus.iob_avalid = 1'b0;
    chk({nm, "_rvalid"}, bus.iob_rvalid, 1'b1);
    chk(nm, bus.iob_rdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rtc_pulse();
    rtc = 1'b1;
    idle(4);
    rtc = 1'b0;
    idle(4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rise;
    int rtc_hold;
    logic [15:0] ad;
    logic [31:0] d;
    int sel;
    int hi;

    arst = 1'b1;
    cke  = 1'b1;
    rtc  = 1'b0;
    bus.iob_avalid = 1'b0;
    bus.iob_addr   = '0;
    bus.iob_wdata  = '0;
    bus.iob_wstrb  = '0;
    idle(3);
    arst   = 1'b0;
    chk_on = 1'b1;

    // Reset state
    chk("rst_mtip",   mtip, 0);
    chk("rst_msip",   msip, 0);
    chk("rst_ssip",   ssip, 0);
    chk("rst_rvalid", bus.iob_rvalid, 0);
    chk("rst_rdata",  bus.iob_rdata, 0);
    chk("rst_ready",  bus.iob_ready, 1);
    do_rd("rst_ctrl",    16'hBFF0, 32'h1);
    do_rd("rst_cmp0_lo", 16'h4000, 32'hFFFF_FFFF);
    do_rd("rst_cmp0_hi", 16'h4004, 32'hFFFF_FFFF);

    // Software interrupt bits
    do_wr(16'h0008, 32'h1, 4'hF);
    chk("msip2", msip, 4'b0100);
    do_wr(16'hC00C, 32'h1, 4'hF);
    chk("ssip3", ssip, 4'b1000);
    do_wr(16'h0014, 32'h1, 4'hF);
    do_rd("msip5_rd", 16'h0014, 32'h0);
    chk("msip_after5", msip, 4'b0100);
    do_wr(16'h0008, 32'h0, 4'h1);
    do_wr(16'hC00C, 32'h0, 4'h1);

    // Prescaler P=3, MTIMECMP[0]=10: rise 41 edges after counting starts
    do_wr(16'h4000, 32'd10, 4'hF);
    do_wr(16'h4004, 32'd0,  4'hF);
    do_wr(16'hBFF4, 32'd3,  4'hF);
    do_wr(16'hBFF0, 32'h3,  4'hF);
    first_rise = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (mtip[0] && first_rise == 0) first_rise = i;
    end
    chk("mtip_rise_cycle", first_rise, 41);
    chk("mtip_stays_high", mtip[0], 1'b1);
    do_wr(16'h4000, 32'd100, 4'hF);
    chk("mtip_before_fall", mtip[0], 1'b1);
    idle(1);
    chk("mtip_fall", mtip[0], 1'b0);

    // External rtc source: 5 pulses at clk/8
    do_wr(16'hBFF0, 32'h1, 4'hF);
    do_wr(16'hBFF8, 32'd0, 4'hF);
    do_wr(16'hBFFC, 32'd0, 4'hF);
    rtc = 1'b1;
    idle(2);
    do_rd("rtc_pre_inc",  16'hBFF8, 32'd0);
    do_rd("rtc_post_inc", 16'hBFF8, 32'd1);
    rtc = 1'b0;
    idle(4);
    repeat (4) rtc_pulse();
    idle(2);
    do_rd("rtc_count5", 16'hBFF8, 32'd5);
    do_rd("rtc_hi0",    16'hBFFC, 32'd0);

    // Wrap from all ones
    do_wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    do_wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    rtc_pulse();
    do_rd("wrap_lo", 16'hBFF8, 32'd0);
    do_rd("wrap_hi", 16'hBFFC, 32'd0);

    // Shadow of high word
    do_wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    do_wr(16'hBFFC, 32'd5, 4'hF);
    do_rd("shadow_lo",  16'hBFF8, 32'hFFFF_FFFF);
    rtc_pulse();
    do_rd("shadow_hi",  16'hBFFC, 32'd5);
    do_rd("shadow_lo2", 16'hBFF8, 32'd0);
    do_rd("shadow_hi2", 16'hBFFC, 32'd6);

    // Write to MTIME_LO on a tick cycle (P=0 ticks every cycle)
    do_wr(16'hBFF4, 32'd0, 4'hF);
    do_wr(16'hBFF0, 32'h3, 4'hF);
    idle(3);
    do_wr(16'hBFF8, 32'h1234, 4'hF);
    do_rd("wr_beats_tick", 16'hBFF8, 32'h1234);

    // Asynchronous reset with a read in flight
    do_wr(16'h0004, 32'h1, 4'h1);
    bus.iob_avalid = 1'b1;
    bus.iob_addr   = 16'hBFF8;
    bus.iob_wstrb  = 4'd0;
    @(negedge clk);
    bus.iob_avalid = 1'b0;
    chk("inflight_rvalid", bus.iob_rvalid, 1'b1);
    arst = 1'b1;
    #1;
    chk("arst_rvalid", bus.iob_rvalid, 1'b0);
    chk("arst_rdata",  bus.iob_rdata, 0);
    chk("arst_msip",   msip, 0);
    chk("arst_mtip",   mtip, 0);
    chk("arst_ssip",   ssip, 0);
    @(negedge clk);
    arst = 1'b0;
    do_rd("arst_ctrl",  16'hBFF0, 32'h1);
    do_rd("arst_mtime", 16'hBFF8, 32'd0);

    // Randomized traffic
    rtc_hold = 3;
    for (int i = 0; i < 3000; i++) begin
      cke = ($urandom_range(0, 9) != 0);
      if (rtc_hold == 0) begin
        rtc      = ~rtc;
        rtc_hold = $urandom_range(2, 6);
      end else begin
        rtc_hold--;
      end
      if ($urandom_range(0, 1) == 1) begin
        sel = $urandom_range(0, 9);
        hi  = $urandom_range(0, 1);
        case (sel)
          0:       ad = 16'($urandom_range(0, 5) * 4);
          1:       ad = 16'('hC000 + $urandom_range(0, 5) * 4);
          3:       ad = 16'hBFF0;
          4:       ad = 16'hBFF4;
          5:       ad = 16'hBFF8;
          6:       ad = 16'hBFFC;
          7:       ad = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h4028;
          default: ad = 16'('h4000 + $urandom_range(0, 4) * 8 + hi * 4);
        endcase
        case (sel)
          3:       d = {$urandom_range(0, 1) == 1 ? 30'h3FFF_FFFF : 30'd0, 2'($urandom_range(0, 3))};
          4:       d = {$urandom_range(0, 1) == 1 ? 16'hFFFF : 16'h0, 16'($urandom_range(0, 4))};
          5:       d = 32'($urandom_range(0, 200));
          6:       d = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'd0;
          0, 1, 7: d = 32'($urandom);
          default: d = (hi == 1) ? (($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'd0)
                                 : 32'($urandom_range(0, 250));
        endcase
        bus.iob_avalid = 1'b1;
        bus.iob_addr   = ad | 16'($urandom_range(0, 3));
        bus.iob_wdata  = d;
        bus.iob_wstrb  = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15));
      end else begin
        bus.iob_avalid = 1'b0;
        bus.iob_wstrb  = 4'd0;
      end
      @(negedge clk);
    end
    bus.iob_avalid = 1'b0;
    cke = 1'b1;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
